// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULT/DIV controller with divide-by-zero check and completion watchdog
//   clk, reset                    : clock, synchronous active-high reset
//   start, op_div, rt             : one-cycle request, op select (1=DIV), divisor checked at start
//   fimDoMult, fimDoDiv           : unit completion flags
//   controleMult, DIV             : unit enables held during RUN
//   MULT, HiWrite, LoWrite        : Hi/Lo write path control
//   busy, done, div_zero_exc, timeout_exc : status and one-cycle result pulses
module mdu_sequencer #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_div,
  input  logic [31:0] rt,
  input  logic        fimDoMult,
  input  logic        fimDoDiv,
  output logic        controleMult,
  output logic        DIV,
  output logic        MULT,
  output logic        HiWrite,
  output logic        LoWrite,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic        timeout_exc
);
  typedef enum logic [2:0] {IDLE, RUN, WRITE, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic op_q, op_d;
  logic tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic fim;
  assign fim = op_q ? fimDoDiv : fimDoMult;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= 1'b0;
      tmo_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      tmo_q <= tmo_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    tmo_d = tmo_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        op_d = op_div;
        tmo_d = 1'b0;
        cnt_d = '0;
        state_d = (op_div && rt == 32'd0) ? ERR : RUN;
      end
      RUN: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        // completion wins over a timeout in the same cycle
        if (fim) state_d = WRITE;
        else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d = ERR;
          tmo_d = 1'b1;
        end
      end
      WRITE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  assign controleMult = (state_q == RUN) && !op_q;
  assign DIV = (state_q == RUN) && op_q;
  // mux select held stable from RUN through DONE around the Hi/Lo write
  assign MULT = (state_q == RUN || state_q == WRITE || state_q == DONE) && !op_q;
  assign HiWrite = state_q == WRITE;
  assign LoWrite = state_q == WRITE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign div_zero_exc = (state_q == ERR) && !tmo_q;
  assign timeout_exc = (state_q == ERR) && tmo_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: table-driven scoreboard bench for mdu_sequencer
module tb_mdu_sequencer;
  localparam int MAXC = 40;
  localparam logic [2:0] C_DONE = 3'b100, C_DZ = 3'b010, C_TO = 3'b001;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, op_div = 1'b0, fimDoMult = 1'b0, fimDoDiv = 1'b0;
  logic [31:0] rt = 32'd0;
  logic controleMult, DIV, MULT, HiWrite, LoWrite, busy, done, div_zero_exc, timeout_exc;
  int n_vec = 0, n_bad = 0;
  mdu_sequencer #(.MAX_CYCLES(MAXC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div), .rt(rt),
    .fimDoMult(fimDoMult), .fimDoDiv(fimDoDiv), .controleMult(controleMult), .DIV(DIV),
    .MULT(MULT), .HiWrite(HiWrite), .LoWrite(LoWrite), .busy(busy), .done(done),
    .div_zero_exc(div_zero_exc), .timeout_exc(timeout_exc)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic op;
    logic [31:0] rt;
    int k;
    bit inj;
    bit rstart;
    logic [2:0] code;
    int en;
    int lat;
  } vec_t;
  typedef struct {
    logic op;
    logic [2:0] code;
    int en;
  } exp_t;
  exp_t q[$];
  vec_t tbl[9];
  int m_cnt = 0, d_cnt = 0, w_cnt = 0;
  logic w_mult = 1'b0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic monitor();
    exp_t e;
    if (reset) begin
      m_cnt = 0; d_cnt = 0; w_cnt = 0;
      return;
    end
    chk("one_enable", {31'd0, controleMult & DIV}, 32'd0);
    m_cnt += int'(controleMult);
    d_cnt += int'(DIV);
    if (HiWrite | LoWrite) begin
      chk("hi_lo_pair", {31'd0, HiWrite}, {31'd0, LoWrite});
      w_cnt++;
      w_mult = MULT;
    end
    if (done | div_zero_exc | timeout_exc) begin
      if (q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_end: got %b want none", {done, div_zero_exc, timeout_exc});
      end else begin
        e = q.pop_front();
        chk("end_code", {29'd0, done, div_zero_exc, timeout_exc}, {29'd0, e.code});
        chk("mult_en_cycles", m_cnt, e.op ? 0 : e.en);
        chk("div_en_cycles", d_cnt, e.op ? e.en : 0);
        chk("write_cycles", w_cnt, e.code == C_DONE ? 1 : 0);
        chk("mult_sel", {31'd0, MULT}, (e.code == C_DONE) ? {31'd0, ~e.op} : 32'd0);
        if (e.code == C_DONE) chk("write_mult_sel", {31'd0, w_mult}, {31'd0, ~e.op});
      end
      m_cnt = 0; d_cnt = 0; w_cnt = 0;
    end
  endtask
  task automatic run_op(input vec_t v);
    int n, lat;
    exp_t e;
    e.op = v.op; e.code = v.code; e.en = v.en;
    q.push_back(e);
    start = 1'b1; op_div = v.op; rt = v.rt;
    tick();
    start = 1'b0;
    n = (v.code == C_DZ) ? 0 : (v.k > 0 ? v.k : MAXC);
    for (int i = 1; i <= n; i++) begin
      if (i == v.k) begin
        if (v.op) fimDoDiv = 1'b1; else fimDoMult = 1'b1;
      end
      if (i == 2) begin
        if (v.inj) begin
          if (v.op) fimDoMult = 1'b1; else fimDoDiv = 1'b1;
        end
        if (v.rstart) begin
          start = 1'b1; op_div = ~v.op; rt = 32'd0;
        end
      end
      tick();
      fimDoMult = 1'b0; fimDoDiv = 1'b0; start = 1'b0;
    end
    lat = 0;
    while (busy && lat < 100) begin
      tick();
      lat++;
    end
    chk("idle_latency", lat, v.lat);
    chk("pending", q.size(), 0);
    q.delete();
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor();
      end
    join_none
    //         op    rt            k   inj rst code    en   lat
    tbl[0] = '{1'b0, 32'd5,        33, 0,  0,  C_DONE, 33,  2};
    tbl[1] = '{1'b1, 32'd7,        10, 1,  0,  C_DONE, 10,  2};
    tbl[2] = '{1'b1, 32'd0,        0,  0,  0,  C_DZ,   0,   1};
    tbl[3] = '{1'b0, 32'd0,        0,  0,  0,  C_TO,   MAXC, 1};
    tbl[4] = '{1'b0, 32'd3,        MAXC, 0, 0, C_DONE, MAXC, 2};
    tbl[5] = '{1'b1, 32'd9,        6,  1,  1,  C_DONE, 6,   2};
    tbl[6] = '{1'b0, 32'd1,        1,  0,  0,  C_DONE, 1,   2};
    tbl[7] = '{1'b1, 32'd3,        0,  0,  0,  C_TO,   MAXC, 1};
    tbl[8] = '{1'b1, 32'hFFFFFFFF, MAXC, 0, 1, C_DONE, MAXC, 2};
    tick(); tick();
    reset = 1'b0;
    chk("reset_outputs", {23'd0, controleMult, DIV, MULT, HiWrite, LoWrite, busy, done, div_zero_exc, timeout_exc}, 32'd0);
    for (int i = 0; i < 9; i++) run_op(tbl[i]);
    start = 1'b1; op_div = 1'b0; rt = 32'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("run_before_reset", {31'd0, controleMult}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_run", {23'd0, controleMult, DIV, MULT, HiWrite, LoWrite, busy, done, div_zero_exc, timeout_exc}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("quiet_after_reset", {31'd0, busy}, 32'd0);
    run_op(tbl[0]);
    run_op(tbl[2]);
    run_op(tbl[1]);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
